// File: rtl/rr_arbiter.sv
// N-way registered arbiter: round-robin or fixed priority, with grant holding
// and a hold timeout that hands the resource to a waiting requester.
module rr_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned RR_EN    = 1,
    parameter int unsigned MAX_HOLD = 4,
    localparam int unsigned IDW     = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id
);

    localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t          state, nxt_state;
    logic [IDW-1:0]  ptr, nxt_ptr;
    logic [HW-1:0]   hold_cnt, nxt_cnt;
    logic [N-1:0]    nxt_grant;
    logic [IDW-1:0]  nxt_id;

    logic [N-1:0]    cand;
    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic [IDW-1:0]  win_ptr;
    logic            owner_req;
    logic            hold_last;
    logic            take;

    // The current owner never competes, so one selector serves idle, release and timeout.
    always_comb begin
        cand      = req & ~grant;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned    idx;
            logic [IDW-1:0] idx_w;
            idx   = (RR_EN != 0) ? ((32'(ptr) + i) % N) : i;
            idx_w = IDW'(idx);
            if (!win_found && cand[idx_w]) begin
                win_found = 1'b1;
                win_idx   = idx_w;
            end
        end
        win_ptr = IDW'((32'(win_idx) + 1) % N);
    end

    assign owner_req = |(req & grant);
    assign hold_last = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD - 1));

    // Next-state and next-output decision.
    always_comb begin
        nxt_state = state;
        nxt_grant = grant;
        nxt_id    = grant_id;
        nxt_ptr   = ptr;
        nxt_cnt   = hold_cnt;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) take = 1'b1;
            end
            OWNED: begin
                if (!owner_req) begin
                    if (win_found) begin
                        take = 1'b1;
                    end else begin
                        nxt_state = IDLE;
                        nxt_grant = '0;
                        nxt_id    = '0;
                        nxt_cnt   = '0;
                    end
                end else if (hold_last && win_found) begin
                    take = 1'b1;
                end else if ((MAX_HOLD != 0) && !hold_last) begin
                    nxt_cnt = hold_cnt + HW'(1);
                end
            end
            default: nxt_state = IDLE;
        endcase
        if (take) begin
            nxt_state = OWNED;
            nxt_grant = N'(1) << win_idx;
            nxt_id    = win_idx;
            nxt_ptr   = win_ptr;
            nxt_cnt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr         <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= nxt_state;
            grant       <= nxt_grant;
            grant_valid <= |nxt_grant;
            grant_id    <= nxt_id;
            ptr         <= nxt_ptr;
            hold_cnt    <= nxt_cnt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: three configurations (RR/hold 4, RR/hold 1, fixed/hold 4)
// share one request bus and are each tracked by an arbitration reference model.
module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;

    logic [7:0] gnt [3];
    logic       vld [3];
    logic [2:0] gid [3];

    int total = 0;
    int bad   = 0;

    int mh [3] = '{4, 1, 4};
    int rr [3] = '{1, 1, 0};
    int m_owner [3];
    int m_cnt   [3];
    int m_ptr   [3];

    always #5 clk = ~clk;

    rr_arbiter #(.N(8), .RR_EN(1), .MAX_HOLD(4)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(gnt[0]), .grant_valid(vld[0]), .grant_id(gid[0]));
    rr_arbiter #(.N(8), .RR_EN(1), .MAX_HOLD(1)) u_mh1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(gnt[1]), .grant_valid(vld[1]), .grant_id(gid[1]));
    rr_arbiter #(.N(8), .RR_EN(0), .MAX_HOLD(4)) u_fp (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(gnt[2]), .grant_valid(vld[2]), .grant_id(gid[2]));

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] vec, input int p, input int use_rr);
        for (int i = 0; i < 8; i++) begin
            int idx;
            idx = (use_rr != 0) ? (p + i) % 8 : i;
            if (((vec >> idx) & 8'h01) != 8'h00) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_owner[k] = -1;
            m_cnt[k]   = 0;
            m_ptr[k]   = 0;
        end
    endtask

    // One arbitration decision from the rules: who owns the resource after this edge.
    task automatic model_step(input int k, input logic [7:0] r);
        logic [7:0] own_bit;
        logic [7:0] others;
        int w;
        own_bit = (m_owner[k] >= 0) ? 8'(1 << m_owner[k]) : 8'h00;
        others  = r & ~own_bit;
        w = -1;
        if (m_owner[k] < 0) begin
            w = pick(r, m_ptr[k], rr[k]);
        end else if ((r & own_bit) == 8'h00) begin
            w = pick(others, m_ptr[k], rr[k]);
            if (w < 0) begin
                m_owner[k] = -1;
                m_cnt[k]   = 0;
            end
        end else if (mh[k] != 0 && m_cnt[k] == mh[k] - 1 && others != 8'h00) begin
            w = pick(others, m_ptr[k], rr[k]);
        end else if (mh[k] != 0 && m_cnt[k] < mh[k] - 1) begin
            m_cnt[k]++;
        end
        if (w >= 0) begin
            m_owner[k] = w;
            m_ptr[k]   = (w + 1) % 8;
            m_cnt[k]   = 0;
        end
    endtask

    function automatic int exp_grant(input int k);
        return (m_owner[k] >= 0) ? (1 << m_owner[k]) : 0;
    endfunction

    function automatic int exp_id(input int k);
        return (m_owner[k] >= 0) ? m_owner[k] : 0;
    endfunction

    // Advance one clock, update the models, then compare every instance.
    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, req);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("m%0d_grant", k), int'(gnt[k]), exp_grant(k));
            check($sformatf("m%0d_valid", k), int'(vld[k]), (m_owner[k] >= 0) ? 1 : 0);
            check($sformatf("m%0d_id", k), int'(gid[k]), exp_id(k));
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset(input logic [7:0] r, input string nm);
        req   = r;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_rst_grant%0d", nm, k), int'(gnt[k]), 0);
            check($sformatf("%s_rst_valid%0d", nm, k), int'(vld[k]), 0);
            check($sformatf("%s_rst_id%0d", nm, k), int'(gid[k]), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [7:0] exp8;
        tbl = '{
            '{8'h81, 8'h01}, '{8'h81, 8'h01}, '{8'h81, 8'h01}, '{8'h81, 8'h01},
            '{8'h81, 8'h80}, '{8'h81, 8'h80}, '{8'h81, 8'h80}, '{8'h81, 8'h80},
            '{8'h81, 8'h01},
            '{8'h04, 8'h04}, '{8'h04, 8'h04}, '{8'h04, 8'h04},
            '{8'h00, 8'h00}, '{8'h00, 8'h00},
            '{8'h02, 8'h02}
        };
        rst_n = 1'b1;
        req   = 8'h00;
        model_model_init: begin end
        #1;

        // Reset with all requests up, then first grant goes to requester 0.
        do_reset(8'hFF, "t1");
        step();
        check("t1_first_grant", int'(gnt[0]), 8'h01);
        check("t1_first_id", int'(gid[0]), 0);

        // Table: timeout alternation, release handover, idle return.
        do_reset(8'h00, "t2");
        for (int i = 0; i < 15; i++) begin
            req = tbl[i].r;
            step();
            check($sformatf("tbl%0d_grant", i), int'(gnt[0]), int'(tbl[i].g));
            check($sformatf("tbl%0d_valid", i), int'(vld[0]), (tbl[i].g != 8'h00) ? 1 : 0);
        end

        // Hold limit of one: grant rotates every cycle.
        do_reset(8'h00, "t4");
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            exp8 = 8'(1 << (i % 8));
            check($sformatf("t4_rot%0d_grant", i), int'(gnt[1]), int'(exp8));
            check($sformatf("t4_rot%0d_id", i), int'(gid[1]), i % 8);
        end

        // Fixed priority: lowest wins, handover on release, timeout preempt.
        do_reset(8'h00, "t5");
        req = 8'h0C; step();
        check("t5_lowest", int'(gnt[2]), 8'h04);
        req = 8'h08; step();
        check("t5_handover", int'(gnt[2]), 8'h08);
        req = 8'h09;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t5_hold%0d", i), int'(gnt[2]), 8'h08);
        end
        step();
        check("t5_timeout", int'(gnt[2]), 8'h01);

        // Mid-hold reset clears immediately and restarts the pointer at 0.
        do_reset(8'h00, "t6a");
        req = 8'h10; step();
        check("t6_owner", int'(gnt[0]), 8'h10);
        step();
        #3;
        do_reset(8'h11, "t6");
        step();
        check("t6_after_rst", int'(gnt[0]), 8'h01);

        // Random traffic with sticky requests so holds and timeouts occur.
        do_reset(8'h00, "rnd");
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(7))
                0: req = 8'($urandom) & 8'($urandom);
                1: req = 8'($urandom);
                2: req = 8'h00;
                default: ;
            endcase
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
